// File: rtl/led_pwm_if.sv
// rtl/led_pwm_if.sv - pattern/brightness/blink settings in, LED drive out
interface led_pwm_if #(
  parameter int WIDTH    = 26,
  parameter int PWM_BITS = 8
);
  logic [WIDTH-1:0]    pattern;
  logic [PWM_BITS-1:0] duty;
  logic [WIDTH-1:0]    blink_en;
  logic [15:0]         blink_period;
  logic [WIDTH-1:0]    led;
  logic                pwm_frame;
  logic                blink_phase;

  modport slave (
    input  pattern, duty, blink_en, blink_period,
    output led, pwm_frame, blink_phase
  );

  modport master (
    output pattern, duty, blink_en, blink_period,
    input  led, pwm_frame, blink_phase
  );
endinterface

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - LED brightness PWM and per-bit blink, settings latched at frame boundaries
module led_pwm_driver #(
  parameter int WIDTH    = 26,
  parameter int PRESCALE = 50,
  parameter int PWM_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  led_pwm_if.slave   bus
);
  localparam int PRE_W = $clog2(PRESCALE);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [15:0]         bcnt_q, bcnt_d;
  logic [WIDTH-1:0]    act_pattern_q, act_pattern_d;
  logic [PWM_BITS-1:0] act_duty_q, act_duty_d;
  logic [WIDTH-1:0]    act_blink_q, act_blink_d;
  logic [15:0]         act_period_q, act_period_d;
  logic                load_pending_q, load_pending_d;
  logic [WIDTH-1:0]    led_q, led_d;
  logic                pwm_frame_q, pwm_frame_d;
  logic                blink_phase_q, blink_phase_d;

  logic        tick;
  logic        fb;
  logic [15:0] period_eff;

  always_comb begin
    tick       = (pre_q == PRE_W'(PRESCALE - 1));
    fb         = tick && (pwm_cnt_q == '1);
    period_eff = (act_period_q == 16'd0) ? 16'd1 : act_period_q;

    pre_d          = tick ? '0 : pre_q + 1'b1;
    pwm_cnt_d      = pwm_cnt_q;
    bcnt_d         = bcnt_q;
    blink_phase_d  = blink_phase_q;
    act_pattern_d  = act_pattern_q;
    act_duty_d     = act_duty_q;
    act_blink_d    = act_blink_q;
    act_period_d   = act_period_q;
    load_pending_d = 1'b0;

    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end

    // Wrap check sees the period active during the frame just ending
    if (fb) begin
      if (bcnt_q == period_eff - 16'd1) begin
        bcnt_d        = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        bcnt_d = bcnt_q + 16'd1;
      end
    end

    if (fb || load_pending_q) begin
      act_pattern_d = bus.pattern;
      act_duty_d    = bus.duty;
      act_blink_d   = bus.blink_en;
      act_period_d  = bus.blink_period;
    end

    led_d       = act_pattern_q & {WIDTH{pwm_cnt_q < act_duty_q}}
                & ~(act_blink_q & {WIDTH{blink_phase_q}});
    pwm_frame_d = fb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q          <= '0;
      pwm_cnt_q      <= '0;
      bcnt_q         <= '0;
      act_pattern_q  <= '0;
      act_duty_q     <= '0;
      act_blink_q    <= '0;
      act_period_q   <= '0;
      load_pending_q <= 1'b1;
      led_q          <= '0;
      pwm_frame_q    <= 1'b0;
      blink_phase_q  <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      pwm_cnt_q      <= pwm_cnt_d;
      bcnt_q         <= bcnt_d;
      act_pattern_q  <= act_pattern_d;
      act_duty_q     <= act_duty_d;
      act_blink_q    <= act_blink_d;
      act_period_q   <= act_period_d;
      load_pending_q <= load_pending_d;
      led_q          <= led_d;
      pwm_frame_q    <= pwm_frame_d;
      blink_phase_q  <= blink_phase_d;
    end
  end

  assign bus.led         = led_q;
  assign bus.pwm_frame   = pwm_frame_q;
  assign bus.blink_phase = blink_phase_q;
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - bench for led_pwm_driver with PRESCALE=2, PWM_BITS=4 (32-cycle frames)
module tb_led_pwm_driver;
  localparam int W = 26;

  logic clk;
  logic reset;

  led_pwm_if #(.WIDTH(W), .PWM_BITS(4)) bus ();

  led_pwm_driver #(.WIDTH(W), .PRESCALE(2), .PWM_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] led;
    logic         pf;
    logic         ph;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference state: frame position 0..31 replaces the prescaler/pwm counter pair
  int           m_pos   = 0;
  logic         m_pend  = 1'b1;
  logic [W-1:0] m_pat   = '0;
  logic [W-1:0] m_blink = '0;
  logic [W-1:0] m_led   = '0;
  logic [3:0]   m_duty  = '0;
  logic [15:0]  m_per   = '0;
  logic [15:0]  m_bcnt  = '0;
  logic         m_phase = 1'b0;
  logic         m_pf    = 1'b0;

  int   a_led0, a_led1, a_pf, a_tog;
  logic prev_ph = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_eval(output exp_t e);
    logic [15:0]  eff;
    logic [W-1:0] lit;
    logic         fb;
    if (reset) begin
      m_pos = 0; m_pend = 1'b1; m_pat = '0; m_blink = '0; m_led = '0;
      m_duty = '0; m_per = '0; m_bcnt = '0; m_phase = 1'b0; m_pf = 1'b0;
    end else begin
      fb    = (m_pos == 31);
      lit   = ((m_pos / 2) < int'(m_duty)) ? {W{1'b1}} : '0;
      m_led = m_pat & lit & ~(m_blink & {W{m_phase}});
      m_pf  = fb;
      if (fb) begin
        eff = (m_per == 16'd0) ? 16'd1 : m_per;
        if (m_bcnt == eff - 16'd1) begin
          m_bcnt  = '0;
          m_phase = ~m_phase;
        end else begin
          m_bcnt = m_bcnt + 16'd1;
        end
      end
      if (fb || m_pend) begin
        m_pat = bus.pattern; m_duty = bus.duty; m_blink = bus.blink_en; m_per = bus.blink_period;
      end
      m_pend = 1'b0;
      m_pos  = (m_pos + 1) % 32;
    end
    e = '{led: m_led, pf: m_pf, ph: m_phase};
  endtask

  task automatic step();
    exp_t e;
    model_eval(e);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sb_led", 32'(bus.led), 32'(e.led));
    chk("sb_pwm_frame", 32'(bus.pwm_frame), 32'(e.pf));
    chk("sb_blink_phase", 32'(bus.blink_phase), 32'(e.ph));
    a_led0 += int'(bus.led[0]);
    a_led1 += int'(bus.led[1]);
    a_pf   += int'(bus.pwm_frame);
    a_tog  += int'(bus.blink_phase != prev_ph);
    prev_ph = bus.blink_phase;
  endtask

  task automatic clr();
    a_led0 = 0; a_led1 = 0; a_pf = 0; a_tog = 0;
  endtask

  task automatic window(input int n);
    clr();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pf(input string tag);
    int n;
    step();
    n = 1;
    while (!bus.pwm_frame && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.pwm_frame), 32'd1);
  endtask

  task automatic wait_toggle(input string tag, input int bound, output int n);
    logic p;
    p = bus.blink_phase;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.blink_phase == p && n < bound);
    chk(tag, 32'(bus.blink_phase != p), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset            = 1'b1;
    bus.pattern      = '1;
    bus.duty         = 4'd8;
    bus.blink_en     = '0;
    bus.blink_period = 16'd1;
    clr();

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_led", 32'(bus.led), 32'd0);
      chk("rst_pwm_frame", 32'(bus.pwm_frame), 32'd0);
      chk("rst_blink_phase", 32'(bus.blink_phase), 32'd0);
    end
    reset = 1'b0;
    step();
    chk("rel_load_cycle_dark", 32'(bus.led), 32'd0);
    step();
    chk("rel_led_on", 32'(bus.led), 32'h3FFFFFF);

    bus.duty = 4'd4;
    wait_pf("duty4_frame");
    window(32);
    chk("duty4_high", a_led0, 8);
    chk("duty4_pf_per_frame", a_pf, 1);
    bus.duty = 4'd0;
    wait_pf("duty0_frame");
    window(32);
    chk("duty0_high", a_led0, 0);
    bus.duty = 4'd15;
    wait_pf("duty15_frame");
    window(32);
    chk("duty15_high", a_led0, 30);
    chk("duty15_pf_per_frame", a_pf, 1);

    bus.pattern = 26'h1;
    bus.duty    = 4'd8;
    wait_pf("glitch_setup_frame");
    for (int i = 0; i < 5; i++) step();
    bus.pattern = 26'h2;
    bus.duty    = 4'd2;
    n = 0;
    do begin
      step();
      n++;
      chk("glitch_hold_bit1", 32'(bus.led[1]), 32'd0);
    end while (!bus.pwm_frame && n < 40);
    chk("glitch_frame", 32'(bus.pwm_frame), 32'd1);
    clr();
    step();
    chk("glitch_switch", 32'(bus.led), 32'h2);
    for (int i = 0; i < 31; i++) step();
    chk("glitch_bit1_high", a_led1, 4);
    chk("glitch_bit0_high", a_led0, 0);

    bus.pattern      = 26'h3;
    bus.blink_en     = 26'h1;
    bus.blink_period = 16'd2;
    bus.duty         = 4'd15;
    wait_pf("blink_load_frame");
    wait_toggle("blink_toggle_a", 200, n);
    wait_toggle("blink_toggle_b", 200, n);
    chk("blink_half_phase", n, 64);
    window(128);
    chk("blink_bit0_high", a_led0, 60);
    chk("blink_bit1_high", a_led1, 120);
    chk("blink_frames", a_pf, 4);
    chk("blink_toggles", a_tog, 2);

    for (int i = 0; i < 32; i++) step();
    bus.blink_period = 16'd0;
    wait_toggle("p0_first_toggle", 40, n);
    wait_toggle("p0_toggle", 40, n);
    chk("p0_interval", n, 32);
    bus.blink_period = 16'd1;
    wait_toggle("p1_first_toggle", 40, n);
    wait_toggle("p1_toggle", 40, n);
    chk("p1_interval", n, 32);

    wait_pf("mid_setup_frame");
    if (bus.blink_phase == 1'b0) wait_pf("mid_setup_frame2");
    chk("mid_phase_pre", 32'(bus.blink_phase), 32'd1);
    for (int i = 0; i < 18; i++) step();
    reset = 1'b1;
    step();
    chk("mid_rst_led", 32'(bus.led), 32'd0);
    chk("mid_rst_pwm_frame", 32'(bus.pwm_frame), 32'd0);
    chk("mid_rst_blink_phase", 32'(bus.blink_phase), 32'd0);
    reset = 1'b0;
    step();
    chk("mid_load_dark", 32'(bus.led), 32'd0);
    step();
    chk("mid_relit", 32'(bus.led), 32'h3);
    n = 2;
    while (!bus.pwm_frame && n < 40) begin
      step();
      n++;
    end
    chk("mid_fresh_frame_len", n, 32);
    window(32);
    chk("mid_bit1_high", a_led1, 30);
    chk("mid_pf_per_frame", a_pf, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
